// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC sequencing controller.
//   state_t : 4-bit encoding of the nine controller states
//   LAT_W   : width of the latency wait counter
//   LAT_MIN / LAT_MAX : legal range of MUL_LAT and ACC_LAT
package mac_ctrl_pkg;

  localparam int LAT_W   = 4;
  localparam int LAT_MIN = 0;
  localparam int LAT_MAX = 15;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLR    = 4'd1,
    S_LD_AB  = 4'd2,
    S_WAIT_M = 4'd3,
    S_LD_M   = 4'd4,
    S_WAIT_A = 4'd5,
    S_LD_ACC = 4'd6,
    S_OUT    = 4'd7,
    S_DONE   = 4'd8
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl_lat_timer.sv
// Loadable down-counter used to time the multiplier and accumulator wait states.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_load           : load i_load_val (takes priority over i_dec)
//   i_load_val       : value loaded
//   i_dec            : decrement by one
//   o_value          : current count
//   o_zero           : count is zero
module lat_timer
  import mac_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [LAT_W-1:0] o_value,
  output logic             o_zero
);

  logic [LAT_W-1:0] r_value;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_dec) begin
      r_value <= r_value - LAT_W'(1);
    end
  end

  assign o_value = r_value;
  assign o_zero  = (r_value == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for the MAC datapath: runs a job of len iterations of
// load A/B -> multiply -> accumulate, then loads the output register and holds
// done until the consumer accepts it.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_go, i_len         : start request (sampled in IDLE) and iteration count
//   i_abort             : cancel the running job
//   i_out_ready         : consumer accepts the result while done is high
//   o_clr_acc .. o_ld_out : datapath strobes (Moore, decoded from state)
//   o_done, o_busy      : result valid / controller active
//   o_idx               : current iteration index (operand address)
//   o_perf_cycles       : cycle count of the last completed job
// Optional build macro: MAC_CTRL_PERF_EN enables the job cycle counter;
// without it o_perf_cycles is tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | waiting for go
// S_CLR    | clear accumulator
// S_LD_AB  | load operands A and B at idx
// S_WAIT_M | multiplier latency wait
// S_LD_M   | capture multiplier result
// S_WAIT_A | accumulator latency wait
// S_LD_ACC | accumulate; advance idx or finish
// S_OUT    | load output register
// S_DONE   | result valid until out_ready
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int MUL_LAT = 1,
  parameter int ACC_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_abort,
  input  logic             i_out_ready,
  output logic             o_clr_acc,
  output logic             o_ld_a,
  output logic             o_ld_b,
  output logic             o_ld_m,
  output logic             o_ld_acc,
  output logic             o_ld_out,
  output logic             o_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_idx,
  output logic [15:0]      o_perf_cycles
);

  if (MUL_LAT < LAT_MIN || MUL_LAT > LAT_MAX) begin : g_bad_mul_lat
    $error("mac_seq_ctrl: MUL_LAT out of range 0..15");
  end
  if (ACC_LAT < LAT_MIN || ACC_LAT > LAT_MAX) begin : g_bad_acc_lat
    $error("mac_seq_ctrl: ACC_LAT out of range 0..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("mac_seq_ctrl: CNT_W must be at least 1");
  end

  // A wait of N cycles is a load of N-1 followed by counting down to zero.
  localparam logic [LAT_W-1:0] MUL_LOAD = (MUL_LAT > 0) ? LAT_W'(MUL_LAT - 1) : '0;
  localparam logic [LAT_W-1:0] ACC_LOAD = (ACC_LAT > 0) ? LAT_W'(ACC_LAT - 1) : '0;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_len_q;
  logic [CNT_W-1:0] r_idx;
  logic             w_last;
  logic             w_tmr_load;
  logic [LAT_W-1:0] w_tmr_load_val;
  logic             w_tmr_dec;
  logic [LAT_W-1:0] w_tmr_val;
  logic             w_tmr_zero;
  logic             w_in_wait;
  logic             w_wait_done;

  assign w_last         = (r_idx == r_len_q - CNT_W'(1));
  assign w_in_wait      = (r_state == S_WAIT_M) || (r_state == S_WAIT_A);
  assign w_tmr_load     = (r_state == S_LD_AB) || (r_state == S_LD_M);
  assign w_tmr_load_val = (r_state == S_LD_AB) ? MUL_LOAD : ACC_LOAD;
  assign w_tmr_dec      = w_in_wait && !w_tmr_zero;
  assign w_wait_done    = (w_tmr_val == '0);

  lat_timer u_lat_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_dec      (w_tmr_dec),
    .o_value    (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_go) w_state_next = S_CLR;
      S_CLR:    w_state_next = (r_len_q == '0) ? S_OUT : S_LD_AB;
      S_LD_AB:  w_state_next = (MUL_LAT > 0) ? S_WAIT_M : S_LD_M;
      S_WAIT_M: if (w_wait_done) w_state_next = S_LD_M;
      S_LD_M:   w_state_next = (ACC_LAT > 0) ? S_WAIT_A : S_LD_ACC;
      S_WAIT_A: if (w_wait_done) w_state_next = S_LD_ACC;
      S_LD_ACC: w_state_next = w_last ? S_OUT : S_LD_AB;
      S_OUT:    w_state_next = S_DONE;
      S_DONE:   if (i_out_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    // Abort wins over out_ready in DONE as well.
    if (i_abort && r_state != S_IDLE) begin
      w_state_next = S_IDLE;
    end
  end

  // idx stays at len_q-1 through OUT/DONE and only clears on the way back to IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx   <= '0;
      r_len_q <= '0;
    end else begin
      if (r_state == S_IDLE && i_go) begin
        r_len_q <= i_len;
      end
      if (w_state_next == S_IDLE) begin
        r_idx <= '0;
      end else if (r_state == S_LD_ACC && !w_last) begin
        r_idx <= r_idx + CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_clr_acc = 1'b0;
    o_ld_a    = 1'b0;
    o_ld_b    = 1'b0;
    o_ld_m    = 1'b0;
    o_ld_acc  = 1'b0;
    o_ld_out  = 1'b0;
    o_done    = 1'b0;
    case (r_state)
      S_CLR:    o_clr_acc = 1'b1;
      S_LD_AB: begin
        o_ld_a = 1'b1;
        o_ld_b = 1'b1;
      end
      S_LD_M:   o_ld_m   = 1'b1;
      S_LD_ACC: o_ld_acc = 1'b1;
      S_OUT:    o_ld_out = 1'b1;
      S_DONE:   o_done   = 1'b1;
      default: ;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_idx  = r_idx;

`ifdef MAC_CTRL_PERF_EN
  logic [15:0] r_perf_cnt;
  logic [15:0] r_perf_out;
  logic [15:0] w_perf_inc;

  assign w_perf_inc = (r_perf_cnt == 16'hFFFF) ? r_perf_cnt : r_perf_cnt + 16'd1;

  // The OUT cycle itself is part of the job, so the published value includes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_cnt <= '0;
      r_perf_out <= '0;
    end else begin
      if (r_state == S_IDLE && i_go) begin
        r_perf_cnt <= '0;
      end else if (r_state != S_IDLE && r_state != S_DONE) begin
        r_perf_cnt <= w_perf_inc;
      end
      if (r_state == S_OUT && !i_abort) begin
        r_perf_out <= w_perf_inc;
      end
    end
  end

  assign o_perf_cycles = r_perf_out;
`else
  assign o_perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst   [2];
  logic             go    [2];
  logic             abrt  [2];
  logic             ready [2];
  logic [CNT_W-1:0] len   [2];

  logic a_clr, a_lda, a_ldb, a_ldm, a_ldacc, a_ldout, a_done, a_busy;
  logic b_clr, b_lda, b_ldb, b_ldm, b_ldacc, b_ldout, b_done, b_busy;
  logic [CNT_W-1:0] a_idx, b_idx;
  logic [15:0]      a_perf, b_perf;
  logic [15:0]      vec_a, vec_b;

  assign vec_a = {a_clr, a_lda, a_ldb, a_ldm, a_ldacc, a_ldout, a_done, a_busy, a_idx};
  assign vec_b = {b_clr, b_lda, b_ldb, b_ldm, b_ldacc, b_ldout, b_done, b_busy, b_idx};

  mac_seq_ctrl #(.CNT_W(CNT_W), .MUL_LAT(1), .ACC_LAT(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst[0]), .i_go(go[0]), .i_len(len[0]),
    .i_abort(abrt[0]), .i_out_ready(ready[0]),
    .o_clr_acc(a_clr), .o_ld_a(a_lda), .o_ld_b(a_ldb), .o_ld_m(a_ldm),
    .o_ld_acc(a_ldacc), .o_ld_out(a_ldout), .o_done(a_done), .o_busy(a_busy),
    .o_idx(a_idx), .o_perf_cycles(a_perf)
  );

  mac_seq_ctrl #(.CNT_W(CNT_W), .MUL_LAT(0), .ACC_LAT(0)) u_dut_b (
    .i_clk(clk), .i_rst(rst[1]), .i_go(go[1]), .i_len(len[1]),
    .i_abort(abrt[1]), .i_out_ready(ready[1]),
    .o_clr_acc(b_clr), .o_ld_a(b_lda), .o_ld_b(b_ldb), .o_ld_m(b_ldm),
    .o_ld_acc(b_ldacc), .o_ld_out(b_ldout), .o_done(b_done), .o_busy(b_busy),
    .o_idx(b_idx), .o_perf_cycles(b_perf)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_perf [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : 0;
  endfunction

  function automatic logic [15:0] obs(input int sel);
    return (sel == 0) ? vec_a : vec_b;
  endfunction

  function automatic logic [15:0] obs_perf(input int sel);
    return (sel == 0) ? a_perf : b_perf;
  endfunction

  // Expected outputs t cycles after the go-accept edge, from the timing rules:
  // CLR at 1, iteration i occupies cycles 2+i*P .. 2+i*P+P-1, OUT at 2+L*P, DONE after.
  // Bits: clr lda ldb ldm ldacc ldout done busy idx[7:0]
  function automatic logic [15:0] exp_vec(input int t, input int L, input int ml, input int al);
    int p, base, k, i;
    logic [15:0] v;
    p    = 3 + ml + al;
    base = 2 + L * p;
    v    = '0;
    v[8] = 1'b1;
    if (t == 1) begin
      v[15] = 1'b1;
    end else if (t < base) begin
      k = (t - 2) % p;
      i = (t - 2) / p;
      v[7:0] = 8'(i);
      if (k == 0) begin
        v[14] = 1'b1;
        v[13] = 1'b1;
      end
      if (k == 1 + ml) v[12] = 1'b1;
      if (k == 2 + ml + al) v[11] = 1'b1;
    end else begin
      v[7:0] = (L == 0) ? 8'd0 : 8'(L - 1);
      if (t == base) v[10] = 1'b1;
      else v[9] = 1'b1;
    end
    return v;
  endfunction

  // Starts in IDLE at a negedge; ends at a negedge in IDLE.
  // kill_at>0 asserts abort (or rst when kill_rst) during cycle kill_at.
  task automatic run_job(input int sel, input int L, input int stall, input int kill_at, input bit kill_rst);
    int ml, al, p, base, t;
    bit ended, hs, killed;
    ml = lat_of(sel);
    al = lat_of(sel);
    p = 3 + ml + al;
    base = 2 + L * p;
    ended = 0; hs = 0; killed = 0;
    len[sel]   = 8'(L);
    go[sel]    = 1'b1;
    abrt[sel]  = 1'b0;
    ready[sel] = 1'($urandom_range(0, 1));
    @(negedge clk);
    for (t = 1; t <= base + stall + 4 && !ended; t++) begin
      if (hs || killed) begin
        chk($sformatf("idle_after dut=%0d L=%0d t=%0d", sel, L, t), {16'h0, obs(sel)}, 32'h0);
        ended = 1;
      end else begin
        chk($sformatf("seq dut=%0d L=%0d t=%0d", sel, L, t), {16'h0, obs(sel)},
            {16'h0, exp_vec(t, L, ml, al)});
        go[sel]   = 1'($urandom_range(0, 1));
        len[sel]  = CNT_W'($urandom);
        abrt[sel] = 1'b0;
        rst[sel]  = 1'b0;
        if (t < base + 1) begin
          ready[sel] = 1'($urandom_range(0, 1));
        end else if (t < base + 1 + stall) begin
          ready[sel] = 1'b0;
        end else begin
          ready[sel] = 1'b1;
          go[sel]    = 1'b0;
          hs = 1;
        end
        if (t == kill_at) begin
          go[sel] = 1'b0;
          killed  = 1;
          if (kill_rst) rst[sel] = 1'b1;
          else abrt[sel] = 1'b1;
        end
        @(negedge clk);
      end
    end
    if (!ended) chk($sformatf("job_end dut=%0d L=%0d", sel, L), 32'h0, 32'h1);
    go[sel] = 1'b0; abrt[sel] = 1'b0; rst[sel] = 1'b0; ready[sel] = 1'b0;
`ifdef MAC_CTRL_PERF_EN
    if (kill_at > 0 && kill_rst) exp_perf[sel] = 0;
    else if (kill_at == 0 || kill_at > base) exp_perf[sel] = (base > 65535) ? 65535 : base;
`endif
    chk($sformatf("perf dut=%0d L=%0d", sel, L), {16'h0, obs_perf(sel)}, 32'(exp_perf[sel]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, L, stall, kat, p;
    bit krst;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; go[i] = 1'b1; abrt[i] = 1'b1; ready[i] = 1'b1; len[i] = '1;
      exp_perf[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_vec dut=%0d", i), {16'h0, obs(i)}, 32'h0);
      chk($sformatf("reset_perf dut=%0d", i), {16'h0, obs_perf(i)}, 32'h0);
      rst[i] = 1'b0; go[i] = 1'b0; abrt[i] = 1'b0; ready[i] = 1'b0; len[i] = '0;
    end
    @(negedge clk);

    run_job(0, 3, 0, 0, 0);
    run_job(1, 2, 0, 0, 0);
    run_job(0, 0, 0, 0, 0);
    run_job(1, 0, 1, 0, 0);
    run_job(0, 2, 5, 0, 0);
    run_job(0, 4, 0, 10, 0);
    run_job(0, 4, 0, 0, 0);
    run_job(0, 3, 0, 4, 1);
    run_job(0, 3, 0, 0, 0);
    run_job(0, 2, 3, 14, 0);
    run_job(0, 255, 1, 0, 0);

    for (int j = 0; j < 40; j++) begin
      sel   = int'($urandom_range(0, 1));
      L     = int'($urandom_range(0, 7));
      stall = int'($urandom_range(0, 3));
      p     = 3 + 2 * lat_of(sel);
      kat   = 0;
      krst  = 0;
      if ($urandom_range(0, 3) == 0) begin
        kat  = int'($urandom_range(1, 2 + L * p + 1 + stall));
        krst = ($urandom_range(0, 2) == 0);
      end
      run_job(sel, L, stall, kat, krst);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
